// File: rtl/i2s_dac_tx.sv
// -----------------------------------------------------------------------------
// i2s_dac_tx
//
// Parallel-in / serial-out transmitter for the codec DAC data line. Samples are
// taken over a valid/ready handshake into a one-word holding register. Each
// rising edge of DACLRC loads the held word into a shift register, which is
// then sent MSB first on DACDAT, one bit per BCLK falling edge. BCLK and DACLRC
// are driven by the codec and are oversampled in the system clock domain, so
// the system clock must run at least 4x the BCLK rate.
//
// Parameters
//   DATA_W       bits per frame word shifted out
//   SYNC_STAGES  synchronizer flops on bclk and daclrc (minimum 2)
//   CNT_W        width of the saturating underrun counter
//
// Ports
//   clock           in   system clock
//   reset_n         in   asynchronous active-low reset
//   bclk            in   codec bit clock (asynchronous to clock)
//   daclrc          in   codec DAC frame clock (asynchronous to clock)
//   din             in   sample word to transmit
//   din_valid       in   din holds a valid word
//   din_ready       out  holding register can accept a word
//   dacdat          out  serial data to codec, MSB first
//   busy            out  word shift in progress
//   frame_done      out  one-cycle pulse when the last bit of a word is driven
//   underrun        out  one-cycle pulse when a frame starts with nothing held
//   underrun_count  out  saturating count of underruns
// -----------------------------------------------------------------------------
module i2s_dac_tx #(
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              bclk,
    input  logic              daclrc,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              dacdat,
    output logic              busy,
    output logic              frame_done,
    output logic              underrun,
    output logic [CNT_W-1:0]  underrun_count
);

    localparam int BCNT_W = $clog2(DATA_W + 1);
    localparam int WARM_W = $clog2(SYNC_STAGES + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_LRC = 2'd1,
        SHIFT    = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Saturating increment for the underrun counter.
    // -------------------------------------------------------------------------
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + CNT_W'(1);
    endfunction

    // -------------------------------------------------------------------------
    // Input synchronizers and edge detection
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] bclk_sync_q;
    logic [SYNC_STAGES-1:0] lrc_sync_q;
    logic                   bclk_prev_q;
    logic                   lrc_prev_q;
    logic                   bclk_cur;
    logic                   lrc_cur;
    logic                   bclk_fall;
    logic                   lrc_rise;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bclk_sync_q <= '0;
            lrc_sync_q  <= '0;
            bclk_prev_q <= 1'b0;
            lrc_prev_q  <= 1'b0;
        end else begin
            bclk_sync_q <= {bclk_sync_q[SYNC_STAGES-2:0], bclk};
            lrc_sync_q  <= {lrc_sync_q[SYNC_STAGES-2:0], daclrc};
            bclk_prev_q <= bclk_cur;
            lrc_prev_q  <= lrc_cur;
        end
    end

    assign bclk_cur  = bclk_sync_q[SYNC_STAGES-1];
    assign lrc_cur   = lrc_sync_q[SYNC_STAGES-1];
    assign bclk_fall = bclk_prev_q & ~bclk_cur;
    assign lrc_rise  = ~lrc_prev_q & lrc_cur;

    // -------------------------------------------------------------------------
    // Synchronizer warm-up. The synchronizer resets to 0, which is not the pad
    // level; IDLE must not treat that reset value as "daclrc is low", or a
    // reset released mid-frame would see a false rising edge a few clocks
    // later. Hold off the IDLE exit until the chain has been filled from the
    // pad.
    // -------------------------------------------------------------------------
    logic [WARM_W-1:0] warm_q;
    logic              warm_done;

    assign warm_done = (warm_q == WARM_W'(SYNC_STAGES));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            warm_q <= '0;
        end else if (!warm_done) begin
            warm_q <= warm_q + WARM_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Holding register
    // -------------------------------------------------------------------------
    state_t              state_q;
    logic [DATA_W-1:0]   hold_q;
    logic [DATA_W-1:0]   hold_d;
    logic                hold_full_q;
    logic                hold_full_d;
    logic                accept;
    logic                load;

    assign accept = din_valid & ~hold_full_q;
    // A frame start is honoured only once the FSM has found a frame boundary.
    assign load   = lrc_rise & (state_q != IDLE);

    // The load samples hold_full_q, not the incoming word: there is no bypass,
    // so a word accepted in the load cycle stays held for the next frame.
    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        if (load) begin
            hold_full_d = 1'b0;
        end
        if (accept) begin
            hold_d      = din;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        hold_q <= hold_d;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hold_full_q <= 1'b0;
        end else begin
            hold_full_q <= hold_full_d;
        end
    end

    assign din_ready = ~hold_full_q;

    // -------------------------------------------------------------------------
    // Transmit state machine with registered outputs
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] shreg_q;
    logic [BCNT_W-1:0] bit_cnt_q;
    logic              dacdat_q;
    logic              busy_q;
    logic              frame_done_q;
    logic              underrun_q;
    logic [CNT_W-1:0]  underrun_cnt_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            shreg_q        <= '0;
            bit_cnt_q      <= '0;
            dacdat_q       <= 1'b0;
            busy_q         <= 1'b0;
            frame_done_q   <= 1'b0;
            underrun_q     <= 1'b0;
            underrun_cnt_q <= '0;
        end else begin
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Wait for a low DACLRC so that a partial frame in flight
                    // at reset release is skipped.
                    if (warm_done && !lrc_cur) begin
                        state_q <= WAIT_LRC;
                    end
                end

                WAIT_LRC, SHIFT: begin
                    if (lrc_rise) begin
                        // Frame start (or resync mid-word). A coincident BCLK
                        // fall is consumed here, so no bit is driven this cycle.
                        state_q   <= SHIFT;
                        busy_q    <= 1'b1;
                        bit_cnt_q <= BCNT_W'(DATA_W);
                        if (hold_full_q) begin
                            shreg_q <= hold_q;
                        end else begin
                            shreg_q        <= '0;
                            underrun_q     <= 1'b1;
                            underrun_cnt_q <= sat_inc(underrun_cnt_q);
                        end
                    end else if (bclk_fall) begin
                        if (state_q == SHIFT) begin
                            dacdat_q  <= shreg_q[DATA_W-1];
                            shreg_q   <= {shreg_q[DATA_W-2:0], 1'b0};
                            bit_cnt_q <= bit_cnt_q - BCNT_W'(1);
                            if (bit_cnt_q == BCNT_W'(1)) begin
                                frame_done_q <= 1'b1;
                                busy_q       <= 1'b0;
                                state_q      <= WAIT_LRC;
                            end
                        end else begin
                            // Between frames the line idles low.
                            dacdat_q <= 1'b0;
                        end
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign dacdat         = dacdat_q;
    assign busy           = busy_q;
    assign frame_done     = frame_done_q;
    assign underrun       = underrun_q;
    assign underrun_count = underrun_cnt_q;

endmodule
